// File: rtl/fx3_burst_reader_pkg.sv
// Shared definitions for the FX3 burst reader: FSM encoding and burst/test-pattern defaults.
// BURST_WORDS default is also consumed by the FIFO dataAvailable threshold logic.
package fx3_burst_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitDma,
        StRead,
        StDrain
    } state_e;

    localparam int unsigned BurstWordsDefault  = 8192;
    localparam int unsigned ReadLatencyDefault = 2;
    localparam logic [15:0] TestStepDefault    = 16'h0040;

endpackage

// File: rtl/fx3_burst_reader_if.sv
// FIFO/FX3-side signal bundle of the burst reader. The reader is the slave view;
// the environment (FIFO, FX3 and control) is the master view.
interface fx3_burst_reader_if;

    logic        enable;
    logic        dataAvailable;
    logic        fx3DmaReady;
    logic        testMode;
    logic [15:0] sampleIn;
    logic        readData;
    logic        fx3Write;
    logic [15:0] fx3Data;
    logic        fx3PktEnd;
    logic        busy;
    logic        seqError;
    logic [15:0] errorCount;

    modport slave (
        input  enable, dataAvailable, fx3DmaReady, testMode, sampleIn,
        output readData, fx3Write, fx3Data, fx3PktEnd, busy, seqError, errorCount
    );

    modport master (
        output enable, dataAvailable, fx3DmaReady, testMode, sampleIn,
        input  readData, fx3Write, fx3Data, fx3PktEnd, busy, seqError, errorCount
    );

endinterface

// File: rtl/fx3_burst_reader_test_pattern_checker.sv
// Checks that valid words follow an incrementing pattern of TEST_STEP; re-seeds on every word
// so a single jump in the sequence produces exactly one error.
module test_pattern_checker
    import fx3_burst_reader_pkg::*;
#(
    parameter logic [15:0] TEST_STEP = TestStepDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [15:0] data,
    input  logic        testMode,
    output logic        seqError,
    output logic [15:0] errorCount
);

    logic        seeded_q, seeded_d;
    logic [15:0] expected_q, expected_d;
    logic        seq_err_q, seq_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        seeded_d   = seeded_q;
        expected_d = expected_q;
        seq_err_d  = seq_err_q;
        err_cnt_d  = err_cnt_q;
        if (!testMode) begin
            // Dropping testMode unseeds, so the next rise starts from a fresh seed.
            seeded_d = 1'b0;
        end else if (valid) begin
            seeded_d   = 1'b1;
            expected_d = data + TEST_STEP;
            if (seeded_q && (data != expected_q)) begin
                seq_err_d = 1'b1;
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seeded_q   <= 1'b0;
            expected_q <= 16'h0000;
            seq_err_q  <= 1'b0;
            err_cnt_q  <= 16'h0000;
        end else begin
            seeded_q   <= seeded_d;
            expected_q <= expected_d;
            seq_err_q  <= seq_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign seqError   = seq_err_q;
    assign errorCount = err_cnt_q;

endmodule

// File: rtl/fx3_burst_reader.sv
// Drains one BURST_WORDS burst from the ADC sample FIFO to the FX3 GPIF bus, gated by the
// FX3 DMA-ready flag, with an optional test-pattern sequence checker.
module fx3_burst_reader
    import fx3_burst_reader_pkg::*;
#(
    parameter int unsigned BURST_WORDS  = BurstWordsDefault,
    parameter int unsigned READ_LATENCY = ReadLatencyDefault,
    parameter logic [15:0] TEST_STEP    = TestStepDefault
) (
    input logic               fx3Clk,
    input logic               reset,
    fx3_burst_reader_if.slave bus
);

    localparam int unsigned CntW = $clog2(BURST_WORDS) + 1;
    localparam logic [CntW-1:0] BurstLen = CntW'(BURST_WORDS);
    localparam logic [CntW-1:0] LastIdx  = CntW'(BURST_WORDS - 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] last_q, last_d;
    logic                    wr_q, wr_d;
    logic                    pkt_q, pkt_d;
    logic [15:0]             data_q, data_d;
    logic                    rd;
    logic                    tap_vld;
    logic                    seq_err;
    logic [15:0]             err_cnt;

    assign tap_vld = vld_q[READ_LATENCY-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.enable && bus.dataAvailable) begin
                    state_d = StWaitDma;
                    cnt_d   = '0;
                end
            end
            StWaitDma: begin
                if (bus.fx3DmaReady) state_d = StRead;
            end
            StRead: begin
                // DMA-ready low only pauses issue; reads already in flight still emit.
                rd = bus.fx3DmaReady && (cnt_q < BurstLen);
                if (rd) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) state_d = StDrain;
                end
            end
            StDrain: begin
                if (vld_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vld_d  = READ_LATENCY'({vld_q, rd});
        last_d = READ_LATENCY'({last_q, rd && (cnt_q == LastIdx)});
        wr_d   = tap_vld;
        pkt_d  = tap_vld && last_q[READ_LATENCY-1];
        data_d = tap_vld ? bus.sampleIn : data_q;
    end

    always_ff @(posedge fx3Clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vld_q   <= '0;
            last_q  <= '0;
            wr_q    <= 1'b0;
            pkt_q   <= 1'b0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            pkt_q   <= pkt_d;
            data_q  <= data_d;
        end
    end

    test_pattern_checker #(
        .TEST_STEP(TEST_STEP)
    ) u_checker (
        .clk       (fx3Clk),
        .reset     (reset),
        .valid     (tap_vld),
        .data      (bus.sampleIn),
        .testMode  (bus.testMode),
        .seqError  (seq_err),
        .errorCount(err_cnt)
    );

    assign bus.readData   = rd;
    assign bus.fx3Write   = wr_q;
    assign bus.fx3Data    = data_q;
    assign bus.fx3PktEnd  = pkt_q;
    assign bus.busy       = (state_q != StIdle) || (vld_q != '0);
    assign bus.seqError   = seq_err;
    assign bus.errorCount = err_cnt;

endmodule
